// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline latch, load-data extraction/extension,
// register-file write port and retired-instruction counter.
module wb_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    input  logic        mem_RegWrite,
    input  logic        mem_MemtoReg,
    input  logic        mem_Link,
    input  logic [2:0]  mem_LoadType,
    input  logic [4:0]  mem_WriteReg,
    input  logic [31:0] mem_ALUResult,
    input  logic [31:0] mem_ReadData,
    input  logic [31:0] mem_PC,
    input  logic        stall,
    input  logic        flush,
    output logic        RegWrite,
    output logic [4:0]  WriteReg,
    output logic [31:0] WriteData,
    output logic        wb_valid,
    output logic [31:0] retired
);

    localparam logic [2:0] LT_LB  = 3'b001;
    localparam logic [2:0] LT_LBU = 3'b010;
    localparam logic [2:0] LT_LH  = 3'b011;
    localparam logic [2:0] LT_LHU = 3'b100;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_to_reg;
        logic        link;
        logic [2:0]  load_type;
        logic [4:0]  write_reg;
        logic [31:0] alu_result;
        logic [31:0] read_data;
        logic [31:0] pc;
    } latch_t;

    latch_t      latch_q, latch_d;
    logic [31:0] retired_q, retired_d;

    // Big-endian lanes: offset 0 is the most significant byte of the word.
    function automatic logic [31:0] extend_load(input logic [2:0]  load_type,
                                                input logic [1:0]  off,
                                                input logic [31:0] word);
        logic [7:0]  byte_s;
        logic [15:0] half_s;
        logic [31:0] result_s;
        case (off)
            2'd0:    byte_s = word[31:24];
            2'd1:    byte_s = word[23:16];
            2'd2:    byte_s = word[15:8];
            default: byte_s = word[7:0];
        endcase
        half_s = off[1] ? word[15:0] : word[31:16];
        case (load_type)
            LT_LB:   result_s = {{24{byte_s[7]}}, byte_s};
            LT_LBU:  result_s = {24'd0, byte_s};
            LT_LH:   result_s = {{16{half_s[15]}}, half_s};
            LT_LHU:  result_s = {16'd0, half_s};
            default: result_s = word;
        endcase
        return result_s;
    endfunction

    // Next-state for the latch (flush beats stall) and the retire counter.
    always_comb begin
        latch_d   = latch_q;
        retired_d = retired_q;
        if (latch_q.valid && !stall) begin
            retired_d = retired_q + 32'd1;
        end else begin
            retired_d = retired_q;
        end
        if (flush) begin
            latch_d = '0;
        end else if (!stall) begin
            latch_d = '{valid:      mem_valid,
                        reg_write:  mem_RegWrite,
                        mem_to_reg: mem_MemtoReg,
                        link:       mem_Link,
                        load_type:  mem_LoadType,
                        write_reg:  mem_WriteReg,
                        alu_result: mem_ALUResult,
                        read_data:  mem_ReadData,
                        pc:         mem_PC};
        end else begin
            latch_d = latch_q;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            latch_q   <= '0;
            retired_q <= 32'd0;
        end else begin
            latch_q   <= latch_d;
            retired_q <= retired_d;
        end
    end

    // Write-port outputs decoded from the latch alone.
    always_comb begin
        RegWrite  = latch_q.valid && latch_q.reg_write && (latch_q.write_reg != 5'd0);
        WriteReg  = latch_q.write_reg;
        wb_valid  = latch_q.valid;
        retired   = retired_q;
        WriteData = latch_q.alu_result;
        if (latch_q.link) begin
            WriteData = latch_q.pc + 32'd8;
        end else if (latch_q.mem_to_reg) begin
            WriteData = extend_load(latch_q.load_type, latch_q.alu_result[1:0], latch_q.read_data);
        end else begin
            WriteData = latch_q.alu_result;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: reference model plus directed literal expectations.
module tb_wb_stage;

    logic        clk, rst_n;
    logic        mem_valid, mem_RegWrite, mem_MemtoReg, mem_Link;
    logic [2:0]  mem_LoadType;
    logic [4:0]  mem_WriteReg;
    logic [31:0] mem_ALUResult, mem_ReadData, mem_PC;
    logic        stall, flush;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic        wb_valid;
    logic [31:0] retired;

    wb_stage dut (
        .clk(clk), .rst_n(rst_n),
        .mem_valid(mem_valid), .mem_RegWrite(mem_RegWrite), .mem_MemtoReg(mem_MemtoReg),
        .mem_Link(mem_Link), .mem_LoadType(mem_LoadType), .mem_WriteReg(mem_WriteReg),
        .mem_ALUResult(mem_ALUResult), .mem_ReadData(mem_ReadData), .mem_PC(mem_PC),
        .stall(stall), .flush(flush),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
        .wb_valid(wb_valid), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic        rw;
        logic        m2r;
        logic        link;
        logic [2:0]  lt;
        logic [4:0]  wr;
        logic [31:0] alu;
        logic [31:0] rd;
        logic [31:0] pc;
    } instr_t;

    instr_t      m_lat;
    logic [31:0] m_ret, ret_bias;
    int          checks, failures;
    logic        mid_chk;

    logic        lit_en, lit_q_en;
    string       lit_name, lit_q_name;
    logic [4:0]  lit_mask, lit_q_mask;
    logic        lit_rw, lit_q_rw, lit_v, lit_q_v;
    logic [4:0]  lit_wr, lit_q_wr;
    logic [31:0] lit_wd, lit_q_wd, lit_ret, lit_q_ret;

    function automatic logic [31:0] load_val(input logic [2:0] lt, input logic [31:0] addr,
                                             input logic [31:0] rd);
        int unsigned off;
        logic [31:0] b, h;
        off = addr % 32'd4;
        b = (rd >> (8 * (3 - off))) & 32'h0000_00FF;
        h = (off >= 2) ? (rd & 32'h0000_FFFF) : (rd >> 16);
        case (lt)
            3'd1:    return (b >= 32'd128) ? (b + 32'hFFFF_FF00) : b;
            3'd2:    return b;
            3'd3:    return (h >= 32'd32768) ? (h + 32'hFFFF_0000) : h;
            3'd4:    return h;
            default: return rd;
        endcase
    endfunction

    function automatic logic [31:0] exp_wd(input instr_t x);
        if (x.link) return x.pc + 32'd8;
        if (x.m2r)  return load_val(x.lt, x.alu, x.rd);
        return x.alu;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Reference model: what the latch and counter must contain after each edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lat    <= '0;
            m_ret    <= 32'd0;
            lit_q_en <= 1'b0;
        end else begin
            if (m_lat.valid && !stall) m_ret <= m_ret + 32'd1;
            if (flush) m_lat.valid <= 1'b0;
            else if (!stall)
                m_lat <= {mem_valid, mem_RegWrite, mem_MemtoReg, mem_Link, mem_LoadType,
                          mem_WriteReg, mem_ALUResult, mem_ReadData, mem_PC};
            lit_q_en   <= lit_en;
            lit_q_name <= lit_name;
            lit_q_mask <= lit_mask;
            lit_q_rw   <= lit_rw;
            lit_q_wr   <= lit_wr;
            lit_q_wd   <= lit_wd;
            lit_q_v    <= lit_v;
            lit_q_ret  <= lit_ret;
        end
    end

    // Single compare process: model every falling edge, literals when requested.
    always @(negedge clk or posedge mid_chk) begin
        if (mid_chk) begin
            chk("async_rst_RegWrite",  32'(RegWrite),  32'd0);
            chk("async_rst_WriteReg",  32'(WriteReg),  32'd0);
            chk("async_rst_WriteData", WriteData,      32'd0);
            chk("async_rst_wb_valid",  32'(wb_valid),  32'd0);
            chk("async_rst_retired",   retired,        32'd0);
        end else begin
            chk("model_RegWrite", 32'(RegWrite),
                32'(m_lat.valid && m_lat.rw && (m_lat.wr != 5'd0)));
            chk("model_wb_valid", 32'(wb_valid), 32'(m_lat.valid));
            chk("model_retired",  retired, m_ret + ret_bias);
            if (!rst_n) begin
                chk("reset_WriteReg",  32'(WriteReg), 32'd0);
                chk("reset_WriteData", WriteData,     32'd0);
            end else if (m_lat.valid) begin
                chk("model_WriteReg",  32'(WriteReg), 32'(m_lat.wr));
                chk("model_WriteData", WriteData,     exp_wd(m_lat));
            end
            if (lit_q_en) begin
                if (lit_q_mask[0]) chk({lit_q_name, "_RegWrite"},  32'(RegWrite), 32'(lit_q_rw));
                if (lit_q_mask[1]) chk({lit_q_name, "_WriteReg"},  32'(WriteReg), 32'(lit_q_wr));
                if (lit_q_mask[2]) chk({lit_q_name, "_WriteData"}, WriteData,     lit_q_wd);
                if (lit_q_mask[3]) chk({lit_q_name, "_wb_valid"},  32'(wb_valid), 32'(lit_q_v));
                if (lit_q_mask[4]) chk({lit_q_name, "_retired"},   retired,       lit_q_ret);
            end
        end
    end

    task automatic drive(input logic v, input logic rw, input logic m2r, input logic lk,
                         input logic [2:0] lt, input logic [4:0] wr,
                         input logic [31:0] alu, input logic [31:0] rd, input logic [31:0] pc);
        mem_valid = v;   mem_RegWrite = rw; mem_MemtoReg = m2r; mem_Link = lk;
        mem_LoadType = lt; mem_WriteReg = wr;
        mem_ALUResult = alu; mem_ReadData = rd; mem_PC = pc;
    endtask

    task automatic drive_rand();
        drive(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
              3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
              $urandom, $urandom, $urandom);
    endtask

    // Expectation for the outputs seen at the falling edge after the next rising edge.
    // mask bits: 0 RegWrite, 1 WriteReg, 2 WriteData, 3 wb_valid, 4 retired.
    task automatic expect_next(input string name, input logic [4:0] mask, input logic rw,
                               input logic [4:0] wr, input logic [31:0] wd, input logic v,
                               input logic [31:0] ret);
        lit_name = name; lit_mask = mask; lit_rw = rw; lit_wr = wr;
        lit_wd = wd; lit_v = v; lit_ret = ret; lit_en = 1'b1;
    endtask

    task automatic step();
        @(negedge clk);
        lit_en = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0; mid_chk = 1'b0; ret_bias = 32'd0;
        lit_en = 1'b0; lit_name = ""; lit_mask = 5'd0; lit_rw = 1'b0; lit_wr = 5'd0;
        lit_wd = 32'd0; lit_v = 1'b0; lit_ret = 32'd0;
        stall = 1'b0; flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed loads, link and $zero write; retired counts each prior instruction.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 5'd4, 32'h0000_1001, 32'h12F4_5678, 32'd0);
        expect_next("lb", 5'b11111, 1'b1, 5'd4, 32'hFFFF_FFF4, 1'b1, 32'd0); step();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 5'd4, 32'h0000_1001, 32'h12F4_5678, 32'd0);
        expect_next("lbu", 5'b11111, 1'b1, 5'd4, 32'h0000_00F4, 1'b1, 32'd1); step();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd3, 5'd6, 32'h0000_2002, 32'h1234_ABCD, 32'd0);
        expect_next("lh", 5'b11111, 1'b1, 5'd6, 32'hFFFF_ABCD, 1'b1, 32'd2); step();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd4, 5'd6, 32'h0000_2002, 32'h1234_ABCD, 32'd0);
        expect_next("lhu", 5'b11111, 1'b1, 5'd6, 32'h0000_ABCD, 1'b1, 32'd3); step();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 5'd31, 32'h0000_1234, 32'd0, 32'h0040_0010);
        expect_next("jal", 5'b11111, 1'b1, 5'd31, 32'h0040_0018, 1'b1, 32'd4); step();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 5'd0, 32'd5, 32'd0, 32'd0);
        expect_next("zero_reg", 5'b11001, 1'b0, 5'd0, 32'd0, 1'b1, 32'd5); step();

        // Stall holds the latch while inputs churn; the held instruction retires once.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 5'd5, 32'hCAFE_F00D, 32'd0, 32'd0);
        expect_next("stall_load", 5'b11111, 1'b1, 5'd5, 32'hCAFE_F00D, 1'b1, 32'd6); step();
        for (int i = 0; i < 3; i++) begin
            stall = 1'b1; drive_rand();
            expect_next("stall_hold", 5'b11111, 1'b1, 5'd5, 32'hCAFE_F00D, 1'b1, 32'd6); step();
        end
        stall = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        expect_next("stall_release", 5'b11001, 1'b0, 5'd0, 32'd0, 1'b0, 32'd7); step();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 5'd6, 32'h0000_0066, 32'd0, 32'd0);
        expect_next("pre_stall_flush", 5'b11001, 1'b1, 5'd0, 32'd0, 1'b1, 32'd7); step();
        stall = 1'b1; flush = 1'b1; drive_rand();
        expect_next("stall_flush", 5'b11001, 1'b0, 5'd0, 32'd0, 1'b0, 32'd7); step();
        stall = 1'b0; flush = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 5'd8, 32'h0000_0077, 32'd0, 32'd0);
        expect_next("pre_flush", 5'b11001, 1'b1, 5'd0, 32'd0, 1'b1, 32'd7); step();
        flush = 1'b1; drive_rand();
        expect_next("flush_retire", 5'b11001, 1'b0, 5'd0, 32'd0, 1'b0, 32'd8); step();
        flush = 1'b0;

        // Randomized traffic with occasional stalls, flushes and resets.
        for (int i = 0; i < 800; i++) begin
            drive_rand();
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 9) == 0);
            step();
            if ($urandom_range(0, 99) == 0) begin
                #1 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        stall = 1'b0; flush = 1'b0;

        // Counter wrap from all-ones.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 5'd7, 32'h0000_0055, 32'd0, 32'd0); step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        #2;
        force dut.retired_q = 32'hFFFF_FFFF;
        ret_bias = 32'hFFFF_FFFF - m_ret;
        #1;
        release dut.retired_q;
        expect_next("wrap", 5'b10000, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0); step();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 5'd9, 32'h0000_0099, 32'd0, 32'd0);
        expect_next("post_wrap", 5'b11111, 1'b1, 5'd9, 32'h0000_0099, 1'b1, 32'd0); step();

        // Asynchronous reset between edges while stalled on a valid instruction.
        stall = 1'b1; drive_rand();
        #2;
        rst_n = 1'b0; ret_bias = 32'd0;
        #2 mid_chk = 1'b1;
        #1 mid_chk = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        expect_next("post_reset", 5'b11001, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0); step();
        stall = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
